// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: access sizes, MMIO register
// offsets, err_status bit positions and the request bundle seen by the decoder.
package dmem_pkg;

    typedef enum logic [1:0] {
        DSIZE_BYTE    = 2'd0,
        DSIZE_HALF    = 2'd1,
        DSIZE_WORD    = 2'd2,
        DSIZE_ILLEGAL = 2'd3
    } dsize_e;

    localparam logic [3:0] MMIO_OFF_CYCLE_LO  = 4'h0;
    localparam logic [3:0] MMIO_OFF_CYCLE_HI  = 4'h4;
    localparam logic [3:0] MMIO_OFF_ERR_STAT  = 4'h8;
    localparam logic [3:0] MMIO_OFF_SCRATCH   = 4'hC;

    localparam int unsigned ERR_W           = 2;
    localparam logic        ERR_BIT_ILLEGAL = 1'b0;
    localparam logic        ERR_BIT_WR_RO   = 1'b1;

    // Where the registered read response word comes from.
    typedef enum logic {
        RSP_SRC_REG = 1'b0,
        RSP_SRC_RAM = 1'b1
    } rsp_src_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        dsize_e      size;
        logic [3:0]  be;
        logic        rd;
        logic        wr;
    } dmem_req_t;

    // Byte-lane merge of lane-aligned store data into an existing word.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/dmem_sram.sv
// Single-port word RAM with byte-lane writes and a registered read port.
// Contents are never reset; the read register holds its value between reads.
module dmem_sram #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk_i,
    input  logic          re_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    input  logic [3:0]    be_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;
    logic [31:0] rdata_d;

    always_comb begin
        rdata_d = rdata_q;
        if (re_i) begin
            rdata_d = mem_q[addr_i];
        end
    end

    always_ff @(posedge clk_i) begin
        rdata_q <= rdata_d;
        if (we_i) begin
            for (int i = 0; i < 4; i++) begin
                if (be_i[i]) begin
                    mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: legality check, RAM and MMIO decode, 64-bit cycle
// counter and one-cycle-latency read/error response registers.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter logic [31:0] MMIO_BASE   = 32'h1000_0000
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [31:0] daddr_i,
    input  logic [31:0] dwdata_i,
    input  logic [1:0]  dsize_i,
    input  logic [3:0]  dbe_i,
    input  logic        drd_i,
    input  logic        dwr_i,
    output logic [31:0] drdata_o,
    output logic        dvalid_o,
    output logic        derr_o
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    dmem_req_t req;
    logic      align_ok;
    logic      in_ram;
    logic      in_mmio;
    logic      legal;
    logic      req_any;
    logic      ram_re;
    logic      ram_we;
    logic      mmio_rd;
    logic      mmio_wr;

    logic [31:0] ram_rdata;
    logic [31:0] mmio_rdata;

    logic [63:0]      counter_q,   counter_d;
    logic [31:0]      hi_shadow_q, hi_shadow_d;
    logic [31:0]      scratch_q,   scratch_d;
    logic [ERR_W-1:0] err_q,       err_d;
    logic [31:0]      rdata_q,     rdata_d;
    rsp_src_e         rsp_src_q,   rsp_src_d;
    logic             dvalid_q,    dvalid_d;
    logic             derr_q,      derr_d;

    // Request decode; requests presented during reset are dropped here.
    always_comb begin
        req = '{addr:  daddr_i,
                wdata: dwdata_i,
                size:  dsize_e'(dsize_i),
                be:    dbe_i,
                rd:    drd_i,
                wr:    dwr_i};

        align_ok = 1'b0;
        case (req.size)
            DSIZE_BYTE: align_ok = 1'b1;
            DSIZE_HALF: align_ok = (req.addr[0] == 1'b0);
            DSIZE_WORD: align_ok = (req.addr[1:0] == 2'b00);
            default:    align_ok = 1'b0;
        endcase

        in_mmio = (req.addr[31:4] == MMIO_BASE[31:4]);
        in_ram  = (32'(req.addr[31:2]) < DEPTH_WORDS);
        legal   = align_ok
                  && (in_mmio ? (req.size == DSIZE_WORD) : in_ram)
                  && !(req.rd && req.wr);

        req_any = (req.rd || req.wr) && !reset_i;
        ram_re  = req_any && legal && !in_mmio && req.rd;
        ram_we  = req_any && legal && !in_mmio && req.wr;
        mmio_rd = req_any && legal && in_mmio && req.rd;
        mmio_wr = req_any && legal && in_mmio && req.wr;
    end

    // MMIO read mux; cycle_hi always comes from the snapshot, never the live counter.
    always_comb begin
        mmio_rdata = 32'h0;
        case (req.addr[3:0])
            MMIO_OFF_CYCLE_LO: mmio_rdata = counter_q[31:0];
            MMIO_OFF_CYCLE_HI: mmio_rdata = hi_shadow_q;
            MMIO_OFF_ERR_STAT: mmio_rdata = 32'(err_q);
            MMIO_OFF_SCRATCH:  mmio_rdata = scratch_q;
            default:           mmio_rdata = 32'h0;
        endcase
    end

    always_comb begin
        counter_d   = counter_q + 64'd1;
        hi_shadow_d = hi_shadow_q;
        scratch_d   = scratch_q;
        err_d       = err_q;
        rdata_d     = rdata_q;
        rsp_src_d   = rsp_src_q;
        dvalid_d    = 1'b0;
        derr_d      = 1'b0;

        if (mmio_rd && (req.addr[3:0] == MMIO_OFF_CYCLE_LO)) begin
            hi_shadow_d = counter_q[63:32];
        end

        if (mmio_wr) begin
            case (req.addr[3:0])
                MMIO_OFF_CYCLE_LO,
                MMIO_OFF_CYCLE_HI: err_d[ERR_BIT_WR_RO] = 1'b1;
                MMIO_OFF_ERR_STAT: err_d = err_d & ~req.wdata[ERR_W-1:0];
                MMIO_OFF_SCRATCH:  scratch_d = merge_bytes(scratch_q, req.wdata, req.be);
                default:           ;
            endcase
        end

        // Setting is applied after the W1C clear so a same-cycle set wins.
        if (req_any && !legal) begin
            err_d[ERR_BIT_ILLEGAL] = 1'b1;
            derr_d                 = 1'b1;
        end

        if (req_any && req.rd) begin
            dvalid_d = 1'b1;
            if (ram_re) begin
                rsp_src_d = RSP_SRC_RAM;
            end else begin
                rsp_src_d = RSP_SRC_REG;
                rdata_d   = mmio_rd ? mmio_rdata : 32'h0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            counter_q   <= 64'h0;
            hi_shadow_q <= 32'h0;
            scratch_q   <= 32'h0;
            err_q       <= '0;
            rdata_q     <= 32'h0;
            rsp_src_q   <= RSP_SRC_REG;
            dvalid_q    <= 1'b0;
            derr_q      <= 1'b0;
        end else begin
            counter_q   <= counter_d;
            hi_shadow_q <= hi_shadow_d;
            scratch_q   <= scratch_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            rsp_src_q   <= rsp_src_d;
            dvalid_q    <= dvalid_d;
            derr_q      <= derr_d;
        end
    end

    dmem_sram #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_sram (
        .clk_i  (clk_i),
        .re_i   (ram_re),
        .we_i   (ram_we),
        .addr_i (req.addr[AW+1:2]),
        .wdata_i(req.wdata),
        .be_i   (req.be),
        .rdata_o(ram_rdata)
    );

    // Both mux inputs are flops and the select is a flop, so the word is stable all cycle.
    assign drdata_o = (rsp_src_q == RSP_SRC_RAM) ? ram_rdata : rdata_q;
    assign dvalid_o = dvalid_q;
    assign derr_o   = derr_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, randomized accesses against
// a behavioural model, plus reset and cycle-counter snapshot sequences.
module tb_dmem_responder;

    localparam int unsigned DEPTH = 256;
    localparam logic [31:0] MMIO  = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [1:0]  dsize;
    logic [3:0]  dbe;
    logic        drd;
    logic        dwr;
    logic [31:0] drdata;
    logic        dvalid;
    logic        derr;

    dmem_responder #(
        .DEPTH_WORDS(DEPTH),
        .MMIO_BASE  (MMIO)
    ) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .daddr_i (daddr),
        .dwdata_i(dwdata),
        .dsize_i (dsize),
        .dbe_i   (dbe),
        .drd_i   (drd),
        .dwr_i   (dwr),
        .drdata_o(drdata),
        .dvalid_o(dvalid),
        .derr_o  (derr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [31:0] m_ram [DEPTH];
    logic [31:0] m_scratch;
    logic [31:0] m_hi;
    logic [31:0] m_last;
    logic [1:0]  m_err;
    logic [63:0] m_cnt;

    always @(posedge clk) m_cnt <= reset ? 64'd0 : m_cnt + 64'd1;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic [3:0]  be;
        logic        exp_v;
        logic        exp_e;
        logic [31:0] exp_d;
    } vec_t;

    vec_t vecs[26];

    logic [31:0] act_d, exp_d;
    logic        act_v, act_e, exp_v, exp_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    function automatic vec_t mk(input logic rd, input logic wr, input logic [31:0] a,
                                input logic [31:0] wd, input logic [1:0] sz, input logic [3:0] be,
                                input logic ev, input logic ee, input logic [31:0] ed);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = a; v.wdata = wd; v.size = sz; v.be = be;
        v.exp_v = ev; v.exp_e = ee; v.exp_d = ed;
        return v;
    endfunction

    task automatic set_idle();
        drd = 1'b0; dwr = 1'b0; daddr = 32'h0; dwdata = 32'h0; dsize = 2'd2; dbe = 4'h0;
    endtask

    task automatic model_reset();
        m_scratch = 32'h0; m_hi = 32'h0; m_last = 32'h0; m_err = 2'b00;
    endtask

    // One access: model computes expectation from the rules, DUT is driven for one cycle.
    task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [1:0] sz, input logic [3:0] be,
                          output logic [31:0] o_act_d, output logic o_act_v, output logic o_act_e,
                          output logic [31:0] o_exp_d, output logic o_exp_v, output logic o_exp_e);
        bit aligned, mmio, inram, legal, req;
        int idx;
        req     = rd || wr;
        aligned = (sz == 2'd0) || (sz == 2'd1 && a[0] == 1'b0) || (sz == 2'd2 && a[1:0] == 2'b00);
        mmio    = (a >> 4) == (MMIO >> 4);
        inram   = (a >> 2) < DEPTH;
        legal   = aligned && (mmio ? (sz == 2'd2) : inram) && !(rd && wr);
        idx     = int'(a >> 2);
        o_exp_v = rd;
        o_exp_e = req && !legal;
        o_exp_d = m_last;
        if (rd) begin
            o_exp_d = 32'h0;
            if (legal && mmio) begin
                case (a[3:0])
                    4'h0: begin o_exp_d = m_cnt[31:0]; m_hi = m_cnt[63:32]; end
                    4'h4: o_exp_d = m_hi;
                    4'h8: o_exp_d = {30'h0, m_err};
                    default: o_exp_d = m_scratch;
                endcase
            end else if (legal) begin
                o_exp_d = m_ram[idx];
            end
            m_last = o_exp_d;
        end
        if (wr && legal) begin
            if (mmio) begin
                case (a[3:0])
                    4'h0, 4'h4: m_err[1] = 1'b1;
                    4'h8: m_err = m_err & ~wd[1:0];
                    default: for (int i = 0; i < 4; i++) if (be[i]) m_scratch[8*i +: 8] = wd[8*i +: 8];
                endcase
            end else begin
                for (int i = 0; i < 4; i++) if (be[i]) m_ram[idx][8*i +: 8] = wd[8*i +: 8];
            end
        end
        if (req && !legal) m_err[0] = 1'b1;

        drd = rd; dwr = wr; daddr = a; dwdata = wd; dsize = sz; dbe = be;
        @(posedge clk);
        #1;
        o_act_d = drdata; o_act_v = dvalid; o_act_e = derr;
        set_idle();
    endtask

    task automatic idle_cycle(input string name);
        set_idle();
        @(posedge clk);
        #1;
        chk({name, "_valid"}, 32'(dvalid), 32'h0);
        chk({name, "_err"},   32'(derr),   32'h0);
        chk({name, "_hold"},  drdata,      m_last);
    endtask

    initial begin
        logic [1:0]  sz;
        logic [31:0] a;
        logic        rd, wr;
        int          r;

        set_idle();
        reset = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", 32'(dvalid), 32'h0);
        chk("reset_err",   32'(derr),   32'h0);
        chk("reset_data",  drdata,      32'h0);
        reset = 1'b0;

        // Directed vectors
        vecs[0]  = mk(0, 1, 32'h10,        32'hDEADBEEF, 2'd2, 4'hF,    0, 0, 32'h0);
        vecs[1]  = mk(1, 0, 32'h10,        32'h0,        2'd2, 4'h0,    1, 0, 32'hDEADBEEF);
        vecs[2]  = mk(0, 1, 32'h12,        32'h0055_0000,2'd0, 4'b0100, 0, 0, 32'hDEADBEEF);
        vecs[3]  = mk(1, 0, 32'h10,        32'h0,        2'd2, 4'h0,    1, 0, 32'hDE55BEEF);
        vecs[4]  = mk(1, 0, 32'h11,        32'h0,        2'd1, 4'h0,    1, 1, 32'h0);
        vecs[5]  = mk(1, 0, MMIO + 32'h8,  32'h0,        2'd2, 4'h0,    1, 0, 32'h1);
        vecs[6]  = mk(0, 1, MMIO + 32'h8,  32'h1,        2'd2, 4'hF,    0, 0, 32'h1);
        vecs[7]  = mk(1, 0, MMIO + 32'h8,  32'h0,        2'd2, 4'h0,    1, 0, 32'h0);
        vecs[8]  = mk(0, 1, 32'h20,        32'h11112222, 2'd2, 4'hF,    0, 0, 32'h0);
        vecs[9]  = mk(1, 1, 32'h20,        32'h1234,     2'd2, 4'hF,    1, 1, 32'h0);
        vecs[10] = mk(1, 0, 32'h20,        32'h0,        2'd2, 4'h0,    1, 0, 32'h11112222);
        vecs[11] = mk(1, 0, MMIO + 32'h8,  32'h0,        2'd2, 4'h0,    1, 0, 32'h1);
        vecs[12] = mk(0, 1, MMIO,          32'h5,        2'd2, 4'hF,    0, 0, 32'h1);
        vecs[13] = mk(1, 0, MMIO + 32'h8,  32'h0,        2'd2, 4'h0,    1, 0, 32'h3);
        vecs[14] = mk(0, 1, MMIO + 32'h8,  32'h3,        2'd2, 4'hF,    0, 0, 32'h3);
        vecs[15] = mk(1, 0, MMIO + 32'h8,  32'h0,        2'd2, 4'h0,    1, 0, 32'h0);
        vecs[16] = mk(0, 1, MMIO + 32'hC,  32'hAABBCCDD, 2'd2, 4'b0011, 0, 0, 32'h0);
        vecs[17] = mk(1, 0, MMIO + 32'hC,  32'h0,        2'd2, 4'h0,    1, 0, 32'h0000CCDD);
        vecs[18] = mk(1, 0, MMIO + 32'hC,  32'h0,        2'd1, 4'h0,    1, 1, 32'h0);
        vecs[19] = mk(1, 0, 32'h400,       32'h0,        2'd2, 4'h0,    1, 1, 32'h0);
        vecs[20] = mk(0, 1, 32'h400,       32'hFFFFFFFF, 2'd2, 4'hF,    0, 1, 32'h0);
        vecs[21] = mk(1, 0, 32'h3FC,       32'h0,        2'd3, 4'h0,    1, 1, 32'h0);
        vecs[22] = mk(0, 1, 32'h1,         32'hFFFF,     2'd1, 4'b0011, 0, 1, 32'h0);
        vecs[23] = mk(1, 0, 32'h12,        32'h0,        2'd1, 4'h0,    1, 0, 32'hDE55BEEF);
        vecs[24] = mk(1, 0, 32'h13,        32'h0,        2'd0, 4'h0,    1, 0, 32'hDE55BEEF);
        vecs[25] = mk(1, 0, MMIO + 32'h8,  32'h0,        2'd2, 4'h0,    1, 0, 32'h1);

        for (int i = 0; i < 26; i++) begin
            access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].size, vecs[i].be,
                   act_d, act_v, act_e, exp_d, exp_v, exp_e);
            chk($sformatf("vec%0d_valid", i), 32'(act_v), 32'(vecs[i].exp_v));
            chk($sformatf("vec%0d_err",   i), 32'(act_e), 32'(vecs[i].exp_e));
            chk($sformatf("vec%0d_data",  i), act_d,      vecs[i].exp_d);
        end
        idle_cycle("idle_after_vecs");

        // Make the low 16 RAM words fully known to the model.
        for (int w = 0; w < 16; w++) begin
            access(0, 1, 32'(w * 4), $urandom(), 2'd2, 4'hF, act_d, act_v, act_e, exp_d, exp_v, exp_e);
        end

        // Randomized accesses against the model
        for (int n = 0; n < 400; n++) begin
            r = int'($urandom_range(0, 5));
            case (r)
                0, 1, 2: a = 32'($urandom_range(0, 63));
                3:       a = MMIO | 32'($urandom_range(0, 15));
                4:       a = 32'(DEPTH * 4) + 32'($urandom_range(0, 255));
                default: a = $urandom() | 32'h8000_0000;
            endcase
            r  = int'($urandom_range(0, 9));
            rd = (r <= 3) || (r == 8);
            wr = (r >= 4 && r <= 8);
            sz = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) sz = 2'd2;
            access(rd, wr, a, $urandom(), sz, 4'($urandom_range(0, 15)),
                   act_d, act_v, act_e, exp_d, exp_v, exp_e);
            chk($sformatf("rnd%0d_valid", n), 32'(act_v), 32'(exp_v));
            chk($sformatf("rnd%0d_err",   n), 32'(act_e), 32'(exp_e));
            chk($sformatf("rnd%0d_data a=%h", n, a), act_d, exp_d);
        end

        // Reset in the middle of a response; requests during reset are dropped.
        access(0, 1, MMIO + 32'hC, 32'h1234_5678, 2'd2, 4'hF, act_d, act_v, act_e, exp_d, exp_v, exp_e);
        drd = 1'b1; daddr = 32'h10; dsize = 2'd2;
        @(posedge clk);
        #1;
        chk("pre_reset_valid", 32'(dvalid), 32'h1);
        chk("pre_reset_data",  drdata,      m_ram[4]);
        reset = 1'b1;
        drd = 1'b0; dwr = 1'b1; daddr = 32'h10; dwdata = 32'hFFFF_FFFF; dbe = 4'hF;
        @(posedge clk);
        #1;
        chk("in_reset_valid", 32'(dvalid), 32'h0);
        chk("in_reset_data",  drdata,      32'h0);
        chk("in_reset_err",   32'(derr),   32'h0);
        drd = 1'b1; dwr = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        idle_cycle("post_reset");
        access(1, 0, 32'h10, 32'h0, 2'd2, 4'h0, act_d, act_v, act_e, exp_d, exp_v, exp_e);
        chk("ram_retained", act_d, exp_d);
        access(1, 0, MMIO + 32'hC, 32'h0, 2'd2, 4'h0, act_d, act_v, act_e, exp_d, exp_v, exp_e);
        chk("scratch_reset", act_d, 32'h0);
        access(1, 0, MMIO + 32'h8, 32'h0, 2'd2, 4'h0, act_d, act_v, act_e, exp_d, exp_v, exp_e);
        chk("err_reset", act_d, 32'h0);
        access(1, 0, MMIO + 32'h4, 32'h0, 2'd2, 4'h0, act_d, act_v, act_e, exp_d, exp_v, exp_e);
        chk("hi_reset", act_d, 32'h0);
        access(1, 0, MMIO, 32'h0, 2'd2, 4'h0, act_d, act_v, act_e, exp_d, exp_v, exp_e);
        chk("counter_after_reset", act_d, exp_d);

        // cycle_hi must return the snapshot taken by the cycle_lo read, not the live counter.
        drd = 1'b1; daddr = MMIO; dsize = 2'd2;
        force dut.counter_q = 64'h0000_0005_FFFF_FFFF;
        @(posedge clk);
        #1;
        release dut.counter_q;
        chk("snap_lo_valid", 32'(dvalid), 32'h1);
        chk("snap_lo_data",  drdata,      32'hFFFF_FFFF);
        set_idle();
        @(posedge clk);
        #1;
        drd = 1'b1; daddr = MMIO + 32'h4; dsize = 2'd2;
        @(posedge clk);
        #1;
        chk("snap_hi_valid", 32'(dvalid), 32'h1);
        chk("snap_hi_data",  drdata,      32'h0000_0005);
        set_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
